// File: rtl/hpf_pkg.sv
// rtl/hpf_pkg.sv - shared widths, FSM encoding and saturation helper for the HPF engine
package hpf_pkg;

  localparam int DATA_W   = 16;
  localparam int STATE_W  = 32;
  localparam int MULT_W   = 18;
  localparam int PROD_W   = 36;
  localparam int PROD_LSB = 3;
  localparam int PROD_MSB = 34;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    UPDATE = 2'd2,
    OUT    = 2'd3
  } fsm_state_t;

  // Clamp a 17-bit two's-complement difference into the 16-bit range.
  function automatic logic [DATA_W-1:0] sat16(input logic [DATA_W:0] d);
    if (d[DATA_W] != d[DATA_W-1])
      sat16 = d[DATA_W] ? 16'h8000 : 16'h7FFF;
    else
      sat16 = d[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/hpf_state_ram.sv
// rtl/hpf_state_ram.sv - per-channel filter state register file, sync clear, async read
module hpf_state_ram
  import hpf_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CH_W-1:0]    rd_addr,
  output logic [STATE_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_addr,
  input  logic [STATE_W-1:0] wr_data
);

  logic [STATE_W-1:0] mem [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < NUM_CH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_addr) < NUM_CH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/hpf_mult_sequencer.sv
// rtl/hpf_mult_sequencer.sv - multi-channel first-order HPF driving a shared pipelined multiplier
// Optional HPF_SATURATE_EN: clamp x - state_hi to 16 bits instead of wrapping.
module hpf_mult_sequencer
  import hpf_pkg::*;
#(
  parameter int NUM_CH       = 32,
  parameter int CH_W         = 5,
  parameter int MULT_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hpf_en,
  input  logic [DATA_W-1:0]   hpf_coef,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_channel,
  input  logic [DATA_W-1:0]   in_data,
  output logic [MULT_W-1:0]   mult_a,
  output logic [MULT_W-1:0]   mult_b,
  input  logic [PROD_W-1:0]   mult_p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_channel,
  output logic [DATA_W-1:0]   out_data
);

  fsm_state_t         state, next_state;
  logic [2:0]         cnt;
  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    rd_addr;
  logic [STATE_W-1:0] rd_data;
  logic [STATE_W-1:0] wr_data;
  logic               wr_en;
  logic [DATA_W-1:0]  state_hi;
  logic [DATA_W:0]    diff;
  logic [DATA_W-1:0]  y_filt;
  logic               accept;
  logic               filt;
  logic               unused_prod;

  assign accept   = in_valid && in_ready;
  assign filt     = hpf_en && (int'(in_channel) < NUM_CH);
  assign rd_addr  = (state == IDLE) ? in_channel : ch;
  assign state_hi = rd_data[30:15];
  assign diff     = {in_data[DATA_W-1], in_data} - {state_hi[DATA_W-1], state_hi};

`ifdef HPF_SATURATE_EN
  assign y_filt = sat16(diff);
`else
  assign y_filt = diff[DATA_W-1:0];
`endif

  // Operands are pre-scaled so the product's [34:3] slice equals y*coef exactly.
  assign wr_data     = rd_data + mult_p[PROD_MSB:PROD_LSB];
  assign unused_prod = ^{mult_p[PROD_W-1], mult_p[PROD_LSB-1:0]};

  hpf_state_ram #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_state_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (ch),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = filt ? MULT : OUT;
      MULT:    if (cnt == 3'd1) next_state = UPDATE;
      UPDATE:  next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == OUT);
    wr_en     = (state == UPDATE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch       <= '0;
      out_data <= '0;
      mult_a   <= '0;
      mult_b   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ch       <= in_channel;
          out_data <= filt ? y_filt : in_data;
          cnt      <= 3'(MULT_LATENCY);
          if (filt) begin
            mult_a <= {y_filt, 2'b00};
            mult_b <= {hpf_coef[DATA_W-1], hpf_coef, 1'b0};
          end
        end
        MULT:   cnt <= cnt - 3'd1;
        UPDATE: begin
          mult_a <= '0;
          mult_b <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_channel = ch;

endmodule

// File: tb/tb_hpf_mult_sequencer.sv
// tb/tb_hpf_mult_sequencer.sv - directed self-checking bench for hpf_mult_sequencer
module tb_hpf_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hpf_en = 1'b0;
  logic [15:0] hpf_coef = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_channel = '0;
  logic [15:0] in_data = '0;
  logic [17:0] mult_a, mult_b;
  logic [35:0] mult_p = '0;
  logic [35:0] p_stage = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_channel;
  logic [15:0] out_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Two-stage multiplier model: product valid two clocks after operands change.
  logic signed [35:0] sa, sb;
  assign sa = {{18{mult_a[17]}}, mult_a};
  assign sb = {{18{mult_b[17]}}, mult_b};
  always @(posedge clk) begin
    p_stage <= sa * sb;
    mult_p  <= p_stage;
  end

  hpf_mult_sequencer #(.NUM_CH(32), .CH_W(5), .MULT_LATENCY(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .hpf_en      (hpf_en),
    .hpf_coef    (hpf_coef),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_channel  (in_channel),
    .in_data     (in_data),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_p      (mult_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_data    (out_data)
  );

  task automatic xact(input logic [4:0] c, input logic [15:0] x, input logic [15:0] k,
                      input logic e, output logic [15:0] d, output logic [4:0] oc,
                      output int n, output logic [17:0] a1, output logic [17:0] b1);
    int w;
    @(negedge clk);
    in_channel = c; in_data = x; hpf_coef = k; hpf_en = e; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 in_valid = 1'b0; hpf_coef = 16'h1234; hpf_en = ~e; in_data = 16'h5555;
    n = 0; a1 = '0; b1 = '0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin a1 = mult_a; b1 = mult_b; end
    end while (!out_valid && n < 30);
    d = out_data; oc = out_channel;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_channel, out_data, mult_a, mult_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b ch=%0d data=%0h a=%0h b=%0h want all 0",
               in_ready, out_valid, out_channel, out_data, mult_a, mult_b);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_filter_basic();
    logic [15:0] d; logic [4:0] oc; int n; logic [17:0] a1, b1;
    xact(5'd0, 16'd40, -16'sd20, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd40) begin bad++; $display("FAIL basic_data0: got %0d want 40", $signed(d)); end
    total++; if (oc !== 5'd0) begin bad++; $display("FAIL basic_ch0: got %0d want 0", oc); end
    total++; if (n !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", n); end
    total++; if (a1 !== 18'd160) begin bad++; $display("FAIL basic_mult_a: got %0h want a0", a1); end
    total++; if (b1 !== 18'h3FFD8) begin bad++; $display("FAIL basic_mult_b: got %0h want 3ffd8", b1); end
    xact(5'd0, 16'd40, -16'sd20, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd41) begin bad++; $display("FAIL basic_data1: got %0d want 41", $signed(d)); end
  endtask

  task automatic test_bypass();
    logic [15:0] d; logic [4:0] oc; int n; logic [17:0] a1, b1;
    xact(5'd3, -16'sd1234, -16'sd20, 1'b0, d, oc, n, a1, b1);
    total++; if (d !== 16'hFB2E) begin bad++; $display("FAIL bypass_data: got %0d want -1234", $signed(d)); end
    total++; if (n !== 1) begin bad++; $display("FAIL bypass_latency: got %0d want 1", n); end
    total++; if ({a1, b1} !== '0) begin bad++; $display("FAIL bypass_mult: got a=%0h b=%0h want 0", a1, b1); end
    total++; if (oc !== 5'd3) begin bad++; $display("FAIL bypass_ch: got %0d want 3", oc); end
    xact(5'd3, 16'd0, -16'sd20, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd0) begin bad++; $display("FAIL bypass_state_kept: got %0d want 0", $signed(d)); end
  endtask

  task automatic test_interleave();
    logic [15:0] d; logic [4:0] oc; int n; logic [17:0] a1, b1;
    xact(5'd1, 16'd1000, 16'd16384, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd1000) begin bad++; $display("FAIL ilv_ch1_first: got %0d want 1000", $signed(d)); end
    xact(5'd2, -16'sd1000, 16'd16384, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'hFC18) begin bad++; $display("FAIL ilv_ch2_first: got %0d want -1000", $signed(d)); end
    xact(5'd1, 16'd0, 16'd16384, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'hFE0C) begin bad++; $display("FAIL ilv_ch1_second: got %0d want -500", $signed(d)); end
    xact(5'd2, 16'd0, 16'd16384, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd500) begin bad++; $display("FAIL ilv_ch2_second: got %0d want 500", $signed(d)); end
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic [4:0] oc; int n; logic [17:0] a1, b1;
    logic [15:0] want;
`ifdef HPF_SATURATE_EN
    want = 16'h8000;
`else
    want = 16'h0001;
`endif
    xact(5'd4, 16'd32767, 16'd32767, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd32767) begin bad++; $display("FAIL ovf_step1: got %0d want 32767", $signed(d)); end
    xact(5'd4, 16'd32767, 16'd32767, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd1) begin bad++; $display("FAIL ovf_step2: got %0d want 1", $signed(d)); end
    xact(5'd4, 16'h8000, 16'd0, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== want) begin bad++; $display("FAIL ovf_edge: got %0d want %0d", $signed(d), $signed(want)); end
  endtask

  task automatic test_hold();
    int w;
    @(negedge clk);
    in_channel = 5'd5; in_data = 16'd100; hpf_coef = 16'd0; hpf_en = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_channel = 5'd6; in_data = 16'd7;
    w = 0;
    do begin @(negedge clk); w++; end while (!out_valid && w < 30);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'd100 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got vld=%0b data=%0d rdy=%0b want 1/100/0", i, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release: got vld=%0b rdy=%0b want 0/1", out_valid, in_ready);
    end
    w = 0;
    repeat (6) begin @(negedge clk); if (out_valid) w++; end
    total++;
    if (w !== 0) begin bad++; $display("FAIL hold_no_accept: got %0d valid cycles want 0", w); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic [4:0] oc; int n; logic [17:0] a1, b1;
    @(negedge clk);
    in_channel = 5'd0; in_data = 16'd500; hpf_coef = 16'd100; hpf_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mult_a !== 18'd2004) begin bad++; $display("FAIL mid_mult_a: got %0d want 2004", mult_a); end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || mult_a !== 18'd0) begin
      bad++; $display("FAIL mid_reset: got vld=%0b a=%0h want 0/0", out_valid, mult_a);
    end
    xact(5'd0, 16'd40, -16'sd20, 1'b1, d, oc, n, a1, b1);
    total++; if (d !== 16'd40) begin bad++; $display("FAIL mid_after_reset: got %0d want 40", $signed(d)); end
  endtask

  initial begin
    test_reset();
    test_filter_basic();
    test_bypass();
    test_interleave();
    test_overflow();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
